// File: rtl/keypad_pkg.sv
// Shared types and tables for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Active-low one-hot column drive, indexed by column number (col[3] = column 0)
    localparam logic [3:0] COL_DRIVE [0:3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Key code {row_idx, col_idx} to the hex legend printed on the keypad
    localparam logic [3:0] KEY_LEGEND [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Returns {valid, idx}: valid only when exactly one row is pulled low (row[3] = row 0)
    function automatic logic [2:0] onehot_low_idx(input logic [3:0] row);
        logic [3:0] low;
        low = ~row;
        case (low)
            4'b1000: return {1'b1, 2'd0};
            4'b0100: return {1'b1, 2'd1};
            4'b0010: return {1'b1, 2'd2};
            4'b0001: return {1'b1, 2'd3};
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_timer.sv
// Free-running column dwell counter; o_tick marks the last cycle of each dwell.
module scan_timer #(
    parameter int SCAN_DIV = 50_000
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(SCAN_DIV - 1));

    // Count 0..SCAN_DIV-1 and wrap
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with per-press debounce and a valid/ready key output.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_RATE    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_overrun
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       r_row_p0, r_row_p1;
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_col_idx, r_row_idx;
    logic [3:0]       r_row_pat;
    logic [CNT_W-1:0] r_match_cnt, r_release_cnt;
    logic [CNT_W-1:0] w_match_inc, w_release_inc;
    logic             w_tick, w_one_low, w_row_match, w_row_idle;
    logic             w_match_done, w_release_done;
    logic [2:0]       w_low;
    logic             w_col_adv, w_latch, w_press, w_repeat, w_confirm;
    logic             r_key_valid, r_key_overrun;
    logic [3:0]       r_key_code;

    scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .i_clk   (clk),
        .i_reset (reset),
        .o_tick  (w_tick)
    );

    assign w_low          = onehot_low_idx(r_row_p1);
    assign w_one_low      = w_low[2];
    assign w_row_match    = (r_row_p1 == r_row_pat);
    assign w_row_idle     = (r_row_p1 == 4'hF);
    assign w_match_inc    = r_match_cnt + 1'b1;
    assign w_release_inc  = r_release_cnt + 1'b1;
    assign w_match_done   = (w_match_inc == CNT_W'(DEBOUNCE_SCANS));
    assign w_release_done = (w_release_inc == CNT_W'(DEBOUNCE_SCANS));
    assign w_confirm      = w_press | w_repeat;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rep_cnt, w_rep_inc;
    logic             r_rep_first, w_rep_due;

    assign w_rep_inc = r_rep_cnt + 1'b1;
    assign w_rep_due = (w_rep_inc == (r_rep_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE)));

    // Dwell count while held: first repeat after REPEAT_DELAY, then every REPEAT_RATE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_press || (r_state == HELD && w_tick && w_row_idle)) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (r_state == HELD && w_tick) begin
            if (w_rep_due) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt <= w_rep_inc;
            end
        end
    end
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    // Two-stage synchroniser for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_p0 <= 4'hF;
            r_row_p1 <= 4'hF;
        end else begin
            r_row_p0 <= row;
            r_row_p1 <= r_row_p0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= SCAN;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state logic, evaluated only at dwell ticks
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCAN:     if (w_tick && w_one_low) w_state_nxt = DEBOUNCE;
            DEBOUNCE: if (w_tick) begin
                          if (!w_row_match)      w_state_nxt = SCAN;
                          else if (w_match_done) w_state_nxt = HELD;
                      end
            HELD:     if (w_tick && w_row_idle && w_release_done) w_state_nxt = SCAN;
            default:  w_state_nxt = SCAN;
        endcase
    end

    // FSM outputs: column drive and per-tick actions
    always_comb begin
        col       = COL_DRIVE[r_col_idx];
        w_col_adv = 1'b0;
        w_latch   = 1'b0;
        w_press   = 1'b0;
        w_repeat  = 1'b0;
        case (r_state)
            SCAN: if (w_tick) begin
                      if (w_one_low) w_latch   = 1'b1;
                      else           w_col_adv = 1'b1;
                  end
            DEBOUNCE: if (w_tick) begin
                      if (!w_row_match)      w_col_adv = 1'b1;
                      else if (w_match_done) w_press   = 1'b1;
                  end
            HELD: begin
                      if (w_tick && w_row_idle && w_release_done) w_col_adv = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                      if (w_tick && !w_row_idle && w_rep_due) w_repeat = 1'b1;
`endif
                  end
            default: ;
        endcase
    end

    // Column index and debounce counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_idx     <= 2'd0;
            r_match_cnt   <= '0;
            r_release_cnt <= '0;
        end else begin
            if (w_col_adv)
                r_col_idx <= r_col_idx + 1'b1;
            if (w_latch)
                r_match_cnt <= '0;
            else if (r_state == DEBOUNCE && w_tick && w_row_match)
                r_match_cnt <= w_match_inc;
            if (w_press)
                r_release_cnt <= '0;
            else if (r_state == HELD && w_tick)
                r_release_cnt <= w_row_idle ? w_release_inc : '0;
        end
    end

    // Capture of the candidate key when a single row is first seen low
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_row_idx <= w_low[1:0];
            r_row_pat <= r_row_p1;
        end
    end

    // Output handshake: load on confirm when free, otherwise flag the dropped key
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_valid   <= 1'b0;
            r_key_code    <= 4'h0;
            r_key_overrun <= 1'b0;
        end else begin
            r_key_overrun <= 1'b0;
            if (w_confirm && (!r_key_valid || key_ready)) begin
                r_key_valid <= 1'b1;
                r_key_code  <= {r_row_idx, r_col_idx};
            end else begin
                if (w_confirm)
                    r_key_overrun <= 1'b1;
                if (r_key_valid && key_ready)
                    r_key_valid <= 1'b0;
            end
        end
    end

    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_overrun = r_key_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix model that pulls a row low
// only while the pressed key's column is driven.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       key_overrun;

    logic       press_en, ghost_en;
    logic [1:0] p_row, p_col;

    int checks  = 0;
    int errors  = 0;
    int acc_cnt = 0;
    int ovr_cnt = 0;
    int chg_cnt = 0;
    int base_acc, base_ovr, base_chg, g, exp_rep;
    logic [3:0] last_code = 4'h0;
    logic [3:0] prev_col  = 4'h0;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .key_overrun (key_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        if (press_en && col == ~(4'b1000 >> p_col))
            row = ~(4'b1000 >> p_row);
        if (ghost_en && col == 4'b1011)
            row = 4'b1001;
    end

    always @(posedge clk) begin
        if (key_valid && key_ready) begin
            acc_cnt   <= acc_cnt + 1;
            last_code <= key_code;
        end
        if (key_overrun)
            ovr_cnt <= ovr_cnt + 1;
        if (col != prev_col)
            chg_cnt <= chg_cnt + 1;
        prev_col <= col;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; key_ready = 1'b0; press_en = 1'b0; ghost_en = 1'b0;
        p_row = 2'd0; p_col = 2'd0;

        // 1. reset values and free-running column sequence
        step(3);
        check("rst_col", col, 4'b0111);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 4'h0);
        check("rst_ovr", key_overrun, 1'b0);
        reset = 1'b0;
        step(3); check("seq_c0", col, 4'b0111);
        step(1); check("seq_c1", col, 4'b1011);
        step(4); check("seq_c2", col, 4'b1101);
        step(4); check("seq_c3", col, 4'b1110);
        step(4); check("seq_wrap", col, 4'b0111);

        // 2. single press row1/col2
        base_acc = acc_cnt;
        p_row = 2'd1; p_col = 2'd2; press_en = 1'b1; key_ready = 1'b1;
        g = 0; while (acc_cnt == base_acc && g < 100) begin step(1); g++; end
        check("t2_wait", 32'(g < 100), 1);
        check("t2_code", last_code, 4'b0110);
        step(40);
        check("t2_col_hold", col, 4'b1101);
        check("t2_one_code", acc_cnt - base_acc, 1);
        press_en = 1'b0;
        g = 0; while (col == 4'b1101 && g < 40) begin step(1); g++; end
        check("t2_rel_col", col, 4'b1110);

        // 3. one-dwell bounce on row0/col0
        base_acc = acc_cnt;
        g = 0; while (col != 4'b0111 && g < 40) begin step(1); g++; end
        check("t3_sync", col, 4'b0111);
        p_row = 2'd0; p_col = 2'd0; press_en = 1'b1;
        step(4);
        press_en = 1'b0;
        step(4);
        check("t3_col", col, 4'b1011);
        check("t3_valid", key_valid, 1'b0);
        step(20);
        check("t3_no_key", acc_cnt - base_acc, 0);

        // 4. backpressure: 3/3 pending, then 0/1 is dropped
        base_acc = acc_cnt; base_ovr = ovr_cnt;
        key_ready = 1'b0;
        p_row = 2'd3; p_col = 2'd3; press_en = 1'b1;
        g = 0; while (!key_valid && g < 100) begin step(1); g++; end
        check("t4_wait", 32'(g < 100), 1);
        check("t4_code", key_code, 4'hF);
        press_en = 1'b0;
        g = 0; while (col == 4'b1110 && g < 40) begin step(1); g++; end
        p_row = 2'd0; p_col = 2'd1; press_en = 1'b1;
        g = 0; while (ovr_cnt == base_ovr && g < 100) begin step(1); g++; end
        check("t4_ovr_wait", 32'(g < 100), 1);
        check("t4_code_hold", key_code, 4'hF);
        check("t4_valid_hold", key_valid, 1'b1);
        press_en = 1'b0;
        step(60);
        check("t4_ovr_once", ovr_cnt - base_ovr, 1);
        check("t4_no_accept", acc_cnt - base_acc, 0);
        key_ready = 1'b1;
        step(20);
        check("t4_one_accept", acc_cnt - base_acc, 1);
        check("t4_accept_code", last_code, 4'hF);
        check("t4_valid_clr", key_valid, 1'b0);

        // 5. ghost pattern keeps scanning; reset during DEBOUNCE
        base_acc = acc_cnt; base_chg = chg_cnt;
        ghost_en = 1'b1;
        step(64);
        check("t5_scanning", chg_cnt - base_chg, 16);
        check("t5_no_key", acc_cnt - base_acc, 0);
        ghost_en = 1'b0;
        p_row = 2'd2; p_col = 2'd1; press_en = 1'b1;
        g = 0; while (col == 4'b1011 && g < 8) begin step(1); g++; end
        g = 0; while (col != 4'b1011 && g < 40) begin step(1); g++; end
        step(5);
        check("t5_in_debounce", col, 4'b1011);
        reset = 1'b1;
        step(1);
        check("t5_rst_col", col, 4'b0111);
        check("t5_rst_valid", key_valid, 1'b0);
        check("t5_rst_code", key_code, 4'h0);
        step(2);
        reset = 1'b0;

        // 6. hold 2/1 for nine dwells after confirm
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        base_acc = acc_cnt;
        g = 0; while (acc_cnt == base_acc && g < 100) begin step(1); g++; end
        check("t6_wait", 32'(g < 100), 1);
        check("t6_code", last_code, 4'h9);
        step(38);
        press_en = 1'b0;
        step(40);
        check("t6_codes", acc_cnt - base_acc, exp_rep);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
